// File: rtl/weight_ram_reader.sv
// ---------------------------------------------------------------------------
// weight_ram_reader
//
// Streams bursts of WeightRAM rows out as individual weight words.
//
// A burst starts in IDLE with Start=1 and reads Count consecutive rows
// beginning at BaseAddr. Each row is captured into a row buffer. Its N_BANK
// words are then presented one per handshake on OutData/OutBank/OutAddr
// using a valid/ready interface. The row address wraps modulo 2^AW.
//
// Optional feature (compile-time macro WEIGHT_READER_CHECKSUM_EN):
//   defined   -> Checksum is a 16-bit running sum of the accepted words.
//                It clears whenever a Start is accepted.
//   undefined -> Checksum is tied to 0 and no accumulator is built.
//
// Ports
//   Clock     in   1           rising-edge clock
//   Rst       in   1           asynchronous, active-high reset
//   Start     in   1           begin a burst (honoured in IDLE only)
//   BaseAddr  in   AW          first row of the burst
//   Count     in   AW+1        number of rows (0..2^AW)
//   RamAddr   out  AW          WeightRAM read address
//   RamWE     out  1           WeightRAM write enable (always 0)
//   RamQ      in   N_BANK*DW   row read data; bank b at [b*DW +: DW]
//   OutData   out  DW          streamed weight word
//   OutBank   out  4           bank index of OutData
//   OutAddr   out  AW          row address of OutData
//   OutValid  out  1           output word valid
//   OutReady  in   1           consumer ready
//   Busy      out  1           high whenever the FSM is not in IDLE
//   Done      out  1           single-cycle pulse at the end of a burst
//   Checksum  out  16          running sum of accepted words (see above)
// ---------------------------------------------------------------------------
module weight_ram_reader #(
  parameter int N_BANK  = 10,
  parameter int DW      = 10,
  parameter int AW      = 7,
  parameter int RAM_LAT = 1
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [AW-1:0]        BaseAddr,
  input  logic [AW:0]          Count,
  output logic [AW-1:0]        RamAddr,
  output logic                 RamWE,
  input  logic [N_BANK*DW-1:0] RamQ,
  output logic [DW-1:0]        OutData,
  output logic [3:0]           OutBank,
  output logic [AW-1:0]        OutAddr,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Busy,
  output logic                 Done,
  output logic [15:0]          Checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [AW-1:0]         r_row;
  logic [AW:0]           r_rows_left;
  logic [3:0]            r_bank;
  logic [1:0]            r_wait;
  logic [N_BANK*DW-1:0]  r_buf;
  logic [DW-1:0]         w_out_data;

  logic w_start_ok;
  logic w_accept;
  logic w_last_bank;
  logic w_more_rows;
  logic w_wait_done;

  assign w_start_ok  = (r_state == S_IDLE) && Start;
  assign w_accept    = (r_state == S_EMIT) && OutReady;
  assign w_last_bank = (r_bank == 4'(N_BANK - 1));
  assign w_more_rows = (r_rows_left > (AW+1)'(1));
  assign w_wait_done = (r_wait == 2'(RAM_LAT - 1));

  // State register
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next = (Count != '0) ? S_ADDR : S_DONE;
        end
      end
      S_ADDR: w_next = S_WAIT;
      S_WAIT: begin
        if (w_wait_done) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_accept && w_last_bank) begin
          w_next = w_more_rows ? S_ADDR : S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row address, row/bank counters, latency counter and row buffer.
  // RamAddr is driven straight from r_row. r_row is loaded on the edge that
  // enters ADDR, so the RAM sees the new address during the ADDR cycle and
  // its data is ready after RAM_LAT more cycles.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_row       <= '0;
      r_rows_left <= '0;
      r_bank      <= '0;
      r_wait      <= '0;
      r_buf       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && (Count != '0)) begin
            r_row       <= BaseAddr;
            r_rows_left <= Count;
            r_bank      <= '0;
          end
        end
        S_ADDR: begin
          r_wait <= '0;
        end
        S_WAIT: begin
          if (w_wait_done) begin
            r_buf  <= RamQ;
            r_bank <= '0;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (w_last_bank) begin
              r_bank <= '0;
              if (w_more_rows) begin
                r_row       <= r_row + AW'(1);
                r_rows_left <= r_rows_left - (AW+1)'(1);
              end
            end else begin
              r_bank <= r_bank + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bank mux out of the row buffer
  always_comb begin
    w_out_data = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (r_bank == 4'(b)) begin
        w_out_data = r_buf[b*DW +: DW];
      end
    end
  end

  assign RamAddr  = r_row;
  assign RamWE    = 1'b0;
  assign OutData  = w_out_data;
  assign OutBank  = r_bank;
  assign OutAddr  = r_row;
  assign OutValid = (r_state == S_EMIT);
  assign Busy     = (r_state != S_IDLE);
  assign Done     = (r_state == S_DONE);

`ifdef WEIGHT_READER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // The word is zero-extended. Wrap-around of the 16-bit sum is intended.
  function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                           input logic [DW-1:0] word);
    return acc + 16'(word);
  endfunction

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= csum_add(r_checksum, w_out_data);
    end
  end

  assign Checksum = r_checksum;
`else
  assign Checksum = 16'd0;
`endif

endmodule

// File: tb/tb_weight_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_weight_ram_reader
//
// Scoreboard bench for weight_ram_reader. It runs with RAM_LAT=3.
// Row r of the RAM model holds the word (10*r + b) mod 2^DW in bank b.
// Starting a burst pushes the expected words into a queue. A monitor runs on
// the falling edge. It pops one entry for each handshake and compares it. It
// also checks that stalled outputs hold, that the gap between rows is right,
// and that Done lasts one cycle.
// ---------------------------------------------------------------------------
module tb_weight_ram_reader;

  localparam int N_BANK = 10;
  localparam int DW     = 10;
  localparam int AW     = 7;
  localparam int LAT    = 3;

  logic                 Clock = 1'b0;
  logic                 Rst;
  logic                 Start;
  logic [AW-1:0]        BaseAddr;
  logic [AW:0]          Count;
  logic [AW-1:0]        RamAddr;
  logic                 RamWE;
  logic [N_BANK*DW-1:0] RamQ;
  logic [DW-1:0]        OutData;
  logic [3:0]           OutBank;
  logic [AW-1:0]        OutAddr;
  logic                 OutValid;
  logic                 OutReady;
  logic                 Busy;
  logic                 Done;
  logic [15:0]          Checksum;

  always #5 Clock = ~Clock;

  weight_ram_reader #(
    .N_BANK (N_BANK),
    .DW     (DW),
    .AW     (AW),
    .RAM_LAT(LAT)
  ) dut (
    .Clock   (Clock),
    .Rst     (Rst),
    .Start   (Start),
    .BaseAddr(BaseAddr),
    .Count   (Count),
    .RamAddr (RamAddr),
    .RamWE   (RamWE),
    .RamQ    (RamQ),
    .OutData (OutData),
    .OutBank (OutBank),
    .OutAddr (OutAddr),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Busy    (Busy),
    .Done    (Done),
    .Checksum(Checksum)
  );

  // Synchronous RAM model with LAT cycles of read latency
  logic [N_BANK*DW-1:0] mem  [2**AW];
  logic [N_BANK*DW-1:0] pipe [LAT];

  always @(posedge Clock) begin
    pipe[0] <= mem[RamAddr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign RamQ = pipe[LAT-1];

  function automatic logic [DW-1:0] word_of(input int row, input int b);
    return DW'((10 * row + b) % (1 << DW));
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    b;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int gap_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic          prev_done  = 1'b0;
  logic [DW-1:0] pd;
  logic [3:0]    pb;
  logic [AW-1:0] pa;
  int            gap  = 0;
  logic          seen = 1'b0;

  always @(negedge Clock) begin
    if (Rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      seen       = 1'b0;
      gap        = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", OutValid, 1);
        check("stall_data_hold", {OutData, OutBank, OutAddr}, {pd, pb, pa});
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", OutData, e.d);
          check("word_bank", OutBank, e.b);
          check("word_addr", OutAddr, e.a);
        end
        acc_cnt++;
      end
      prev_stall = OutValid && !OutReady;
      pd = OutData;
      pb = OutBank;
      pa = OutAddr;

      if (OutValid) begin
        if (seen && gap > 0) begin
          gap_cnt++;
          check("row_gap", gap, LAT + 1);
        end
        gap  = 0;
        seen = 1'b1;
      end else if (Busy && seen) begin
        gap++;
      end
      if (!Busy) begin
        seen = 1'b0;
        gap  = 0;
      end

      if (Done) begin
        done_cnt++;
        if (prev_done) check("done_width", 2, 1);
      end
      prev_done = Done;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_burst(input int base, input int cnt);
    for (int r = 0; r < cnt; r++) begin
      int row;
      row = (base + r) % (1 << AW);
      for (int b = 0; b < N_BANK; b++) begin
        exp_q.push_back('{d: word_of(row, b), b: 4'(b), a: AW'(row)});
      end
    end
  endtask

  // Issues a burst and waits for Done. In stall mode OutReady follows the
  // repeating pattern 1,0,0,1. In hold mode Start stays high until Done.
  task automatic run_burst(input int base, input int cnt,
                           input bit stall, input bit hold);
    logic [3:0] pat;
    bit         got;
    pat = 4'b1001;
    got = 1'b0;
    push_burst(base, cnt);
    Start    = 1'b1;
    BaseAddr = AW'(base);
    Count    = (AW+1)'(cnt);
    tick();
    if (!hold) Start = 1'b0;
    for (int k = 0; k < 800; k++) begin
      OutReady = stall ? pat[3 - (k % 4)] : 1'b1;
      tick();
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    Start    = 1'b0;
    OutReady = 1'b1;
    check("done_seen", got, 1);
    tick();
    check("busy_after_done", Busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int a0;
    int g0;
    Rst      = 1'b1;
    Start    = 1'b0;
    BaseAddr = '0;
    Count    = '0;
    OutReady = 1'b1;
    for (int r = 0; r < (1 << AW); r++) begin
      for (int b = 0; b < N_BANK; b++) mem[r][b*DW +: DW] = word_of(r, b);
    end

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs",
          {RamAddr, RamWE, OutData, OutBank, OutAddr, OutValid, Busy, Done, Checksum}, 0);
    Rst = 1'b0;
    tick();

    // Rows 5 and 6, continuous ready
    d0 = done_cnt;
    g0 = gap_cnt;
    run_burst(5, 2, 1'b0, 1'b0);
    check("done_count_basic", done_cnt - d0, 1);
    check("gap_seen_basic", gap_cnt - g0, 1);
`ifdef WEIGHT_READER_CHECKSUM_EN
    check("checksum_basic", Checksum, 1190);
`else
    check("checksum_basic", Checksum, 0);
`endif

    // Address wrap 127 -> 0
    d0 = done_cnt;
    run_burst(127, 2, 1'b0, 1'b0);
    check("done_count_wrap", done_cnt - d0, 1);
    check("ramaddr_wrapped", RamAddr, 0);

    // Back-pressure pattern
    d0 = done_cnt;
    run_burst(10, 1, 1'b1, 1'b0);
    check("done_count_stall", done_cnt - d0, 1);

    // Count = 0
    d0 = done_cnt;
    a0 = acc_cnt;
    Start    = 1'b1;
    BaseAddr = AW'(55);
    Count    = '0;
    tick();
    Start = 1'b0;
    check("zero_done_pulse", Done, 1);
    check("zero_ramaddr_kept", RamAddr, 10);
    check("zero_valid", OutValid, 0);
    tick();
    check("zero_done_end", Done, 0);
    check("zero_busy_end", Busy, 0);
    check("zero_checksum", Checksum, 0);
    check("zero_no_words", acc_cnt - a0, 0);
    check("done_count_zero", done_cnt - d0, 1);

    // Reset during a burst, after the 4th word
    push_burst(20, 3);
    Start    = 1'b1;
    BaseAddr = AW'(20);
    Count    = (AW+1)'(3);
    tick();
    Start = 1'b0;
    a0 = acc_cnt - 0;
    d0 = done_cnt;
    for (int k = 0; k < 300; k++) begin
      if (acc_cnt >= a0 + 4) break;
      tick();
    end
    check("abort_words_before_reset", acc_cnt - a0, 4);
    Rst = 1'b1;
    #1;
    check("abort_reset_outputs",
          {RamAddr, RamWE, OutData, OutBank, OutAddr, OutValid, Busy, Done, Checksum}, 0);
    exp_q.delete();
    tick();
    Rst = 1'b0;
    tick();
    tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", Busy, 0);
    d0 = done_cnt;
    run_burst(0, 1, 1'b0, 1'b0);
    check("done_count_after_abort", done_cnt - d0, 1);

    // Start held high for the whole burst
    d0 = done_cnt;
    g0 = gap_cnt;
    a0 = acc_cnt;
    run_burst(30, 2, 1'b0, 1'b1);
    check("hold_word_count", acc_cnt - a0, 2 * N_BANK);
    check("hold_done_count", done_cnt - d0, 1);
    check("hold_gap_seen", gap_cnt - g0, 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_ram_reader.md
WEIGHT_RAM_READER -- requirements
Module: weight_ram_reader

Interface
REQ-001 Parameters (name, default, meaning): N_BANK, 10, number of WeightRAM banks per row.
REQ-002 DW, 10, weight word width in bits.
REQ-003 AW, 7, WeightRAM address width in bits.
REQ-004 RAM_LAT, 1, cycles from RamAddr change to valid RamQ (legal range 1..3).
REQ-005 Ports (name, direction, width, meaning): Clock, in, 1, single clock for all logic, rising edge.
REQ-006 Rst, in, 1, reset; asynchronous, active-high.
REQ-007 Start, in, 1, request to begin a read burst; sampled in IDLE only.
REQ-008 BaseAddr, in, AW, first row address of the burst.
REQ-009 Count, in, AW+1, number of rows to read (0..2^AW).
REQ-010 RamAddr, out, AW, address driven to WeightRAM.
REQ-011 RamWE, out, 1, WeightRAM write enable; constant 0 (read only).
REQ-012 RamQ, in, N_BANK*DW, packed row; bank b occupies bits [b*DW +: DW].
REQ-013 OutData, out, DW, streamed weight word.
REQ-014 OutBank, out, 4, bank index of OutData.
REQ-015 OutAddr, out, AW, row address of OutData.
REQ-016 OutValid, out, 1, OutData/OutBank/OutAddr valid.
REQ-017 OutReady, in, 1, consumer accepts the word when OutValid=1 and OutReady=1 on a rising edge.
REQ-018 Busy, out, 1, high in every state except IDLE.
REQ-019 Done, out, 1, one-cycle pulse at burst end.
REQ-020 Checksum, out, 16, running sum of accepted words (see Configuration).

Function
REQ-021 The FSM SHALL have states IDLE, ADDR, WAIT, EMIT, DONE.
REQ-022 IDLE: Start=1 with Count!=0 SHALL latch BaseAddr and Count and go to ADDR; Start=1 with Count=0 SHALL go directly to DONE without driving a new RamAddr.
REQ-023 ADDR: RamAddr SHALL take the current row address; next state WAIT.
REQ-024 WAIT: the block SHALL remain exactly RAM_LAT cycles, then capture RamQ into an N_BANK-word row buffer and go to EMIT with bank index 0.
REQ-025 EMIT: OutValid=1, OutData=row buffer[bank], OutBank=bank, OutAddr=current row.
REQ-026 While OutValid=1 and OutReady=0, OutData, OutBank, and OutAddr SHALL hold stable.
REQ-027 Each handshake SHALL increment bank by one; OutValid SHALL stay high across back-to-back handshakes, giving one word per cycle when OutReady=1.
REQ-028 On acceptance of bank N_BANK-1: if rows remaining > 1, the row address SHALL increment modulo 2^AW (127 wraps to 0) and the FSM SHALL go to ADDR; otherwise go to DONE.
REQ-029 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-030 Start asserted outside IDLE SHALL be ignored.
REQ-031 Total words per burst SHALL be Count*N_BANK; the minimum row-to-row gap is 1+RAM_LAT cycles with OutValid=0.

Reset
REQ-032 Rst=1 SHALL immediately force IDLE, RamAddr=0, RamWE=0, OutData=0, OutBank=0, OutAddr=0, OutValid=0, Busy=0, Done=0, Checksum=0, and clear the row buffer.
REQ-033 Rst asserted mid-burst SHALL abort the burst with no Done pulse; the first Start after reset release SHALL begin a fresh burst.

Configuration
REQ-034 Macro WEIGHT_READER_CHECKSUM_EN defined: Checksum SHALL clear on each accepted Start and add each accepted OutData, zero-extended, modulo 2^16.
REQ-035 Macro undefined: Checksum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-036 Rows 5 and 6 preloaded with bank b = 10*row+b; BaseAddr=5, Count=2, OutReady=1 -> 20 words 50..59, 60..69 with OutBank 0..9; Done pulses once; Checksum=1190 with the macro, 0 without.
REQ-037 BaseAddr=127, Count=2 -> OutAddr 127 then 0; RamAddr wraps to 0.
REQ-038 OutReady toggled 1,0,0,1 during EMIT -> no word lost or duplicated; OutData stable during the stall cycles.
REQ-039 Count=0 with Start=1 -> Done one cycle later; OutValid is never asserted; RamAddr is unchanged.
REQ-040 Rst pulsed after the 4th word of a Count=3 burst -> all outputs return to reset values in the same cycle and no Done pulses; a new burst with BaseAddr=0, Count=1 streams 10 correct words.
REQ-041 Start held high during a burst and RAM_LAT=3 -> the burst is not restarted; each row shows a 4-cycle OutValid=0 gap.
